async_fifo_wr_arbiter: RTL and testbench
========================================

Name: async_fifo_wr_arbiter

Overview:
Round-robin write-port arbiter that shares the write side of the async FIFO among NREQ requesters, all in the wrclk domain. Grants one requester at a time and locks it for bursts of up to MAX_BURST words, which keeps a requester's data contiguous in the FIFO. Drives the FIFO push/wrdata and honours the FIFO full flag.

Parameters:
NREQ, 4, number of requesters (>= 2)
DWIDTH, 8, data width; matches the FIFO DWIDTH
MAX_BURST, 4, maximum consecutive words granted to one owner (>= 1)

Ports:
wrclk  input  1  write-domain clock; single clock for this block
reset_L  input  1  asynchronous, active-low reset
req  input  NREQ  per-requester write request; held high with data stable until granted
req_data  input  NREQ*DWIDTH  requester i data in bits [i*DWIDTH +: DWIDTH]
gnt  output  NREQ  one-hot; gnt[i]=1 means req_data[i] is written at this wrclk edge
full  input  1  FIFO full flag
push  output  1  FIFO write enable
wrdata  output  DWIDTH  FIFO write data
owner  output  IDX_W  index of the current/last owner; IDX_W = max(1, $clog2(NREQ))
lock  output  1  high while in the BURST state

Behaviour:
- Grant path is combinational from registered state, req and full. push = |gnt. wrdata = req_data[owner slot] when push is 1, else 0.
- A grant never occurs while full=1, so the FIFO cannot overflow.
- Registered state: fsm (IDLE/BURST), rr_ptr[IDX_W], cnt (counts 0..MAX_BURST), owner_q.
- Reset (async, reset_L=0): fsm=IDLE, rr_ptr=0, cnt=0, owner_q=0. Outputs: gnt=0, push=0, wrdata=0, lock=0, owner=0. Reset mid-burst aborts the burst immediately; no partial state survives.
- IDLE:
  - pick = first i with req[i]=1, searching from rr_ptr upward with wrap mod NREQ.
  - If any req and full=0: gnt[pick]=1 and owner_q<=pick.
    - If MAX_BURST==1: stay IDLE and set rr_ptr<=pick+1 mod NREQ.
    - Else: go to BURST with cnt<=1.
  - If full=1 or no req: no grant; state, rr_ptr and cnt are unchanged.
- BURST (owner = owner_q):
  - req[owner]=1 and full=0: gnt[owner]=1 and cnt<=cnt+1. If cnt+1==MAX_BURST: go to IDLE, rr_ptr<=owner+1 mod NREQ, cnt<=0.
  - req[owner]=1 and full=1: hold. No grant; cnt is unchanged.
  - req[owner]=0: release. No grant this cycle (one bubble); go to IDLE, rr_ptr<=owner+1, cnt<=0. Other requests are ignored in the release cycle.
- Non-owner requests are never granted during BURST.
- An IDLE grant can occur in the cycle right after a burst ends, so a max-length burst adds no bubble.
- owner output = owner_q, except in IDLE with a grant, where it equals pick. lock = (fsm==BURST).
- Wrap: rr_ptr and pick indices wrap modulo NREQ; NREQ need not be a power of two.
- Starvation bound: a continuously requesting port waits at most (NREQ-1)*MAX_BURST grants, plus any full-stall cycles.

Decomposition:
- Package async_fifo_pkg holds:
  - typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t
  - function clog2_min1(int n), used for IDX_W
- Sub-module async_fifo_rr_pick: purely combinational rotating-priority finder. Inputs req[NREQ] and rr_ptr; outputs valid and idx. It is instantiated once.

Test Plan:
- Reset: hold reset_L=0 with req=4'hF and full=0 -> gnt=0, push=0, wrdata=0, lock=0, owner=0. After release, the first grant goes to requester 0.
- Single requester (NREQ=4, MAX_BURST=4): req=4'b0100 held, data 8'hA0..A7 -> push high for 8 consecutive cycles, gnt=4'b0100 on all of them, wrdata=A0..A7 in order, and lock drops for exactly 1 cycle (the IDLE re-grant after the 4th word).
- Fairness: req=4'hF continuous, full=0 -> gnt sequence is 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0,... with no idle cycles. Also with rr_ptr=3 and req=4'b0011 -> requester 0 is granted first.
- Full stall: full=1 for 3 cycles after the 2nd word of requester 1's burst -> push=0, gnt=0, lock=1 and cnt held during the stall. After full drops, exactly 2 more words are granted, then owner advances to 2.
- Early release: requester 2 drops req after 2 words while req[3]=1 -> 1 bubble cycle with push=0, then gnt=4'b1000 on the following cycle.
- Reset mid-burst: assert reset_L=0 after the 3rd word of requester 1 -> outputs are zero in the same cycle (async). After release, arbitration restarts from requester 0, not 2.

Source files
------------

// File: rtl/async_fifo_pkg.sv
// =============================================================================
// Module      : async_fifo_pkg
// Description : Shared types and helpers for the async FIFO write-side logic.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package async_fifo_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

    // Index width that never collapses to zero bits for tiny counts.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/async_fifo_rr_pick.sv
// =============================================================================
// Module      : async_fifo_rr_pick
// Description : Combinational rotating-priority finder starting at rr_ptr.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module async_fifo_rr_pick #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // Walk offsets from the far end back to zero so the closest one wins.
    always_comb begin : p_pick
        int w_cand;
        valid  = |req;
        idx    = '0;
        w_cand = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_cand = int'(rr_ptr) + k;
            if (w_cand >= NREQ) w_cand = w_cand - NREQ;
            if (req[w_cand]) idx = IDX_W'(w_cand);
        end
    end

endmodule

`default_nettype wire

// File: rtl/async_fifo_wr_arbiter.sv
// =============================================================================
// Module      : async_fifo_wr_arbiter
// Description : Round-robin burst-locking arbiter for the async FIFO write port.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module async_fifo_wr_arbiter
    import async_fifo_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int DWIDTH    = 8,
    parameter int MAX_BURST = 4,
    localparam int IDX_W    = clog2_min1(NREQ)
) (
    input  logic                     wrclk,
    input  logic                     reset_L,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DWIDTH-1:0]   req_data,
    output logic [NREQ-1:0]          gnt,
    input  logic                     full,
    output logic                     push,
    output logic [DWIDTH-1:0]        wrdata,
    output logic [IDX_W-1:0]         owner,
    output logic                     lock
);

    localparam int             CNT_W     = clog2_min1(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] c_max_cnt = CNT_W'(MAX_BURST);

    arb_state_t         r_state;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_owner;

    logic               w_pick_valid;
    logic [IDX_W-1:0]   w_pick_idx;
    logic [NREQ-1:0]    w_gnt;
    logic [IDX_W-1:0]   w_owner;
    logic [DWIDTH-1:0]  w_slot [NREQ];

    function automatic logic [IDX_W-1:0] f_next(input logic [IDX_W-1:0] idx);
        return (int'(idx) == NREQ - 1) ? '0 : idx + IDX_W'(1);
    endfunction

    generate
        for (genvar i = 0; i < NREQ; i++) begin : g_slot
            assign w_slot[i] = req_data[i*DWIDTH +: DWIDTH];
        end
    endgenerate

    async_fifo_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (req),
        .rr_ptr (r_rr_ptr),
        .valid  (w_pick_valid),
        .idx    (w_pick_idx)
    );

    // Grants are gated by reset so the port goes quiet the instant reset asserts.
    always_comb begin
        w_gnt   = '0;
        w_owner = r_owner;
        if (reset_L && !full) begin
            if (r_state == ARB_IDLE) begin
                if (w_pick_valid) begin
                    w_gnt[w_pick_idx] = 1'b1;
                    w_owner           = w_pick_idx;
                end
            end else if (req[r_owner]) begin
                w_gnt[r_owner] = 1'b1;
            end
        end
    end

    assign gnt    = w_gnt;
    assign push   = |w_gnt;
    assign owner  = w_owner;
    assign wrdata = push ? w_slot[w_owner] : '0;
    assign lock   = (r_state == ARB_BURST);

    always_ff @(posedge wrclk or negedge reset_L) begin
        if (!reset_L) begin
            r_state  <= ARB_IDLE;
            r_rr_ptr <= '0;
            r_cnt    <= '0;
            r_owner  <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_pick_valid && !full) begin
                        r_owner <= w_pick_idx;
                        if (MAX_BURST == 1) begin
                            r_rr_ptr <= f_next(w_pick_idx);
                        end else begin
                            r_state <= ARB_BURST;
                            r_cnt   <= CNT_W'(1);
                        end
                    end
                end
                ARB_BURST: begin
                    if (req[r_owner]) begin
                        if (!full) begin
                            if (r_cnt + CNT_W'(1) == c_max_cnt) begin
                                r_state  <= ARB_IDLE;
                                r_rr_ptr <= f_next(r_owner);
                                r_cnt    <= '0;
                            end else begin
                                r_cnt <= r_cnt + CNT_W'(1);
                            end
                        end
                    end else begin
                        // Owner let go: spend one bubble cycle and hand priority on.
                        r_state  <= ARB_IDLE;
                        r_rr_ptr <= f_next(r_owner);
                        r_cnt    <= '0;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_async_fifo_wr_arbiter.sv
// =============================================================================
// Module      : tb_async_fifo_wr_arbiter
// Description : Scoreboard bench for the async FIFO write-port arbiter.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_async_fifo_wr_arbiter;

    logic        wrclk;
    logic        reset_L;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic        full;
    logic        push;
    logic [7:0]  wrdata;
    logic [1:0]  owner;
    logic        lock;

    typedef struct {
        logic [3:0] g;
        logic [7:0] d;
        logic [1:0] o;
        logic       l;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;

    async_fifo_wr_arbiter #(
        .NREQ      (4),
        .DWIDTH    (8),
        .MAX_BURST (4)
    ) dut (
        .wrclk    (wrclk),
        .reset_L  (reset_L),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .full     (full),
        .push     (push),
        .wrdata   (wrdata),
        .owner    (owner),
        .lock     (lock)
    );

    initial wrclk = 1'b0;
    always #5 wrclk = ~wrclk;

    function automatic logic [31:0] mk(input logic [7:0] s0, input logic [7:0] s1,
                                       input logic [7:0] s2, input logic [7:0] s3);
        return {s3, s2, s1, s0};
    endfunction

    // One cycle of stimulus; a grant cycle queues its expected word, others are checked idle.
    task automatic cyc(input logic [3:0] r, input logic f, input logic [31:0] d,
                       input logic ep, input logic [3:0] eg, input logic [1:0] eo,
                       input logic el, input string name);
        exp_t e;
        logic [31:0] dv;
        req      = r;
        full     = f;
        req_data = d;
        if (ep) begin
            dv  = d;
            e.g = eg;
            e.d = dv[eo*8 +: 8];
            e.o = eo;
            e.l = el;
            exp_q.push_back(e);
        end else begin
            #1;
            checks++;
            if (push !== 1'b0 || gnt !== 4'b0 || lock !== el) begin
                errors++;
                $display("FAIL %s: push=%b gnt=%b lock=%b, required push=0 gnt=0000 lock=%b",
                         name, push, gnt, lock, el);
            end
        end
        @(posedge wrclk);
        #1;
    endtask

    initial begin : p_monitor
        exp_t e;
        forever begin
            @(negedge wrclk);
            if (reset_L && push) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_push: gnt=%b wrdata=%h owner=%0d, required no push",
                             gnt, wrdata, owner);
                end else begin
                    e = exp_q.pop_front();
                    if (gnt !== e.g || wrdata !== e.d || owner !== e.o || lock !== e.l) begin
                        errors++;
                        $display("FAIL grant_word: gnt=%b wrdata=%h owner=%0d lock=%b, required gnt=%b wrdata=%h owner=%0d lock=%b",
                                 gnt, wrdata, owner, lock, e.g, e.d, e.o, e.l);
                    end
                end
            end
        end
    end

    initial begin : p_driver
        int r;
        checks   = 0;
        errors   = 0;
        reset_L  = 1'b0;
        req      = 4'hF;
        full     = 1'b0;
        req_data = mk(8'h11, 8'h22, 8'h33, 8'h44);
        repeat (2) @(posedge wrclk);
        #1;
        checks++;
        if (gnt !== 4'b0 || push !== 1'b0 || wrdata !== 8'h00 || lock !== 1'b0 || owner !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs: gnt=%b push=%b wrdata=%h lock=%b owner=%0d, required all zero",
                     gnt, push, wrdata, lock, owner);
        end
        reset_L = 1'b1;

        // All four requesting: four-word bursts in rotation, no idle cycles.
        for (int k = 0; k < 20; k++) begin
            r = (k / 4) % 4;
            cyc(4'hF, 1'b0, mk(8'h11, 8'h22, 8'h33, 8'h44), 1'b1, 4'(1 << r), 2'(r),
                (k % 4) != 0, "fair");
        end
        cyc(4'b0000, 1'b0, '0, 1'b0, 4'b0, 2'd0, 1'b0, "no_req_idle");
        cyc(4'b0100, 1'b1, '0, 1'b0, 4'b0, 2'd0, 1'b0, "full_idle");

        // Single requester 2: eight words back to back, lock low once mid-stream.
        for (int k = 0; k < 8; k++) begin
            cyc(4'b0100, 1'b0, mk(8'h00, 8'h00, 8'(8'hA0 + k), 8'h00), 1'b1, 4'b0100, 2'd2,
                (k % 4) != 0, "single");
        end

        // Pointer now at 3: requester 0 wins over 1.
        for (int k = 0; k < 4; k++) begin
            cyc(4'b0011, 1'b0, mk(8'h0A, 8'h0B, 8'h00, 8'h00), 1'b1, 4'b0001, 2'd0,
                k != 0, "wrap_pick");
        end

        // Requester 1 stalled by full after its second word.
        cyc(4'b0110, 1'b0, mk(8'h00, 8'hC1, 8'hD0, 8'h00), 1'b1, 4'b0010, 2'd1, 1'b0, "stall_w1");
        cyc(4'b0110, 1'b0, mk(8'h00, 8'hC2, 8'hD0, 8'h00), 1'b1, 4'b0010, 2'd1, 1'b1, "stall_w2");
        for (int k = 0; k < 3; k++) begin
            cyc(4'b0110, 1'b1, mk(8'h00, 8'hC3, 8'hD0, 8'h00), 1'b0, 4'b0, 2'd0, 1'b1, "stall_hold");
        end
        cyc(4'b0110, 1'b0, mk(8'h00, 8'hC3, 8'hD0, 8'h00), 1'b1, 4'b0010, 2'd1, 1'b1, "stall_w3");
        cyc(4'b0110, 1'b0, mk(8'h00, 8'hC4, 8'hD0, 8'h00), 1'b1, 4'b0010, 2'd1, 1'b1, "stall_w4");
        cyc(4'b0110, 1'b0, mk(8'h00, 8'hC5, 8'hD1, 8'h00), 1'b1, 4'b0100, 2'd2, 1'b0, "after_stall");

        // Requester 2 releases after two words; requester 3 follows one bubble later.
        cyc(4'b1100, 1'b0, mk(8'h00, 8'h00, 8'hD2, 8'hE0), 1'b1, 4'b0100, 2'd2, 1'b1, "early_w2");
        cyc(4'b1000, 1'b0, mk(8'h00, 8'h00, 8'h00, 8'hE0), 1'b0, 4'b0, 2'd0, 1'b1, "early_bubble");
        cyc(4'b1000, 1'b0, mk(8'h00, 8'h00, 8'h00, 8'hE1), 1'b1, 4'b1000, 2'd3, 1'b0, "early_next");
        cyc(4'b1000, 1'b0, mk(8'h00, 8'h00, 8'h00, 8'hE2), 1'b1, 4'b1000, 2'd3, 1'b1, "early_next2");
        cyc(4'b0000, 1'b0, '0, 1'b0, 4'b0, 2'd0, 1'b1, "release3");

        // Requester 1 interrupted by reset after its third word.
        cyc(4'b0010, 1'b0, mk(8'h00, 8'hF1, 8'h00, 8'h00), 1'b1, 4'b0010, 2'd1, 1'b0, "rst_w1");
        cyc(4'b0010, 1'b0, mk(8'h00, 8'hF2, 8'h00, 8'h00), 1'b1, 4'b0010, 2'd1, 1'b1, "rst_w2");
        cyc(4'b0010, 1'b0, mk(8'h00, 8'hF3, 8'h00, 8'h00), 1'b1, 4'b0010, 2'd1, 1'b1, "rst_w3");
        req     = 4'b0010;
        reset_L = 1'b0;
        #1;
        checks++;
        if (gnt !== 4'b0 || push !== 1'b0 || wrdata !== 8'h00 || lock !== 1'b0 || owner !== 2'd0) begin
            errors++;
            $display("FAIL midburst_reset: gnt=%b push=%b wrdata=%h lock=%b owner=%0d, required all zero",
                     gnt, push, wrdata, lock, owner);
        end
        @(posedge wrclk);
        #1;
        reset_L = 1'b1;
        cyc(4'b0101, 1'b0, mk(8'h5A, 8'h00, 8'hA5, 8'h00), 1'b1, 4'b0001, 2'd0, 1'b0, "post_reset");
        cyc(4'b0000, 1'b0, '0, 1'b0, 4'b0, 2'd0, 1'b1, "post_release");
        cyc(4'b0000, 1'b0, '0, 1'b0, 4'b0, 2'd0, 1'b0, "final_idle");

        repeat (2) @(posedge wrclk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d words never pushed, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
